// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: turns byte/half/word loads and stores into
// word-aligned req/ready bus transactions, stalling the core until each completes.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        done_o,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_wstrb_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ready_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] addr_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;

   logic        take;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [31:0] ld_shift;
   logic [31:0] ld_data;

   // Illegal funct3 encodings are reported on the same flag as misalignment.
   always_comb begin
      misalign_o = 1'b0;
      if (mem_req_i) begin
         case (funct3_i)
            3'd0:    misalign_o = 1'b0;
            3'd1:    misalign_o = addr_i[0];
            3'd2:    misalign_o = |addr_i[1:0];
            3'd4:    misalign_o = mem_we_i;
            3'd5:    misalign_o = mem_we_i | addr_i[0];
            default: misalign_o = 1'b1;
         endcase
      end
   end

   always_comb begin
      st_wstrb = 4'b0000;
      st_wdata = 32'd0;
      if (mem_we_i) begin
         case (funct3_i[1:0])
            2'd0: begin
               st_wdata = {4{wdata_i[7:0]}};
               st_wstrb = 4'b0001 << addr_i[1:0];
            end
            2'd1: begin
               st_wdata = {2{wdata_i[15:0]}};
               st_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               st_wdata = wdata_i;
               st_wstrb = 4'b1111;
            end
         endcase
      end
   end

   // Halfword loads are aligned, so the byte shift also selects the halfword.
   always_comb begin
      ld_shift = bus_rdata_i >> {off_q, 3'b000};
      case (f3_q)
         3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'd4:    ld_data = {24'd0, ld_shift[7:0]};
         3'd5:    ld_data = {16'd0, ld_shift[15:0]};
         default: ld_data = bus_rdata_i;
      endcase
      if (we_q) ld_data = 32'd0;
   end

   assign take    = (state_q == S_IDLE) && mem_req_i && !misalign_o;
   assign cnt_inc = cnt_q + 32'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               state_d = S_BUS;
               cnt_d   = 32'd0;
            end
         end
         S_BUS: begin
            if (bus_ready_i) begin
               state_d = S_DONE;
               rdata_d = ld_data;
            end else begin
               cnt_d = cnt_inc;
               if (TIMEOUT != 0 && cnt_inc == TIMEOUT) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         addr_q  <= 32'd0;
         wstrb_q <= 4'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (take) begin
            we_q    <= mem_we_i;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            addr_q  <= {addr_i[31:2], 2'b00};
            wstrb_q <= st_wstrb;
            wdata_q <= st_wdata;
         end
      end
   end

   assign rdata_o     = rdata_q;
   assign done_o      = (state_q == S_DONE);
   assign bus_err_o   = err_q;
   assign stall_o     = !reset && (take || state_q == S_BUS);
   assign bus_req_o   = (state_q == S_BUS);
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_wstrb_o = wstrb_q;
   assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each task drives one scenario and checks inline.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        done, stall, misalign, bus_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .funct3_i(funct3),
      .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata), .done_o(done), .stall_o(stall), .misalign_o(misalign),
      .bus_err_o(bus_err), .bus_req_o(bus_req), .bus_we_o(bus_we),
      .bus_addr_o(bus_addr), .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
      .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
      mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
      #1;
   endtask

   task automatic drop();
      mem_req = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus_ready = 1'b0; bus_rdata = 32'd0;
      go(1'b0, 3'd2, 32'h100, 32'd0);
      tick();
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
      tests++;
      if ({done, bus_err, bus_req, bus_we} !== 4'b0000) begin
         fails++; $display("FAIL reset_flags got %b want 0000", {done, bus_err, bus_req, bus_we});
      end
      tests++;
      if ({rdata, bus_addr, bus_wdata, bus_wstrb} !== 100'd0) begin
         fails++; $display("FAIL reset_regs got %h/%h/%h/%h want all 0", rdata, bus_addr, bus_wdata, bus_wstrb);
      end
      drop();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_load_byte();
      bus_rdata = 32'h80FF1234; bus_ready = 1'b1;
      go(1'b0, 3'd0, 32'h103, 32'd0);
      tests++;
      if ({stall, bus_req, misalign} !== 3'b100) begin
         fails++; $display("FAIL lb_cycle0 got stall/req/mis=%b want 100", {stall, bus_req, misalign});
      end
      tick();
      tests++;
      if ({bus_req, bus_we, bus_addr, bus_wstrb} !== {2'b10, 32'h100, 4'b0000}) begin
         fails++; $display("FAIL lb_bus got req=%b we=%b addr=%h strb=%b want 1 0 00000100 0000", bus_req, bus_we, bus_addr, bus_wstrb);
      end
      tick();
      tests++;
      if ({done, stall, bus_req} !== 3'b100 || rdata !== 32'hFFFFFF80) begin
         fails++; $display("FAIL lb_done got done=%b stall=%b rdata=%h want 1 0 ffffff80", done, stall, rdata);
      end
      tick();
      go(1'b0, 3'd4, 32'h103, 32'd0);
      tick(); tick();
      tests++;
      if (done !== 1'b1 || rdata !== 32'h00000080) begin
         fails++; $display("FAIL lbu_done got done=%b rdata=%h want 1 00000080", done, rdata);
      end
      tick();
      drop();
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL lbu_pulse got done=%b want 0", done); end
   endtask

   task automatic test_timeout();
      int n = 0;
      bus_ready = 1'b0;
      go(1'b0, 3'd2, 32'h200, 32'd0);
      tick();
      while (bus_req && n < 30) begin
         n++;
         tick();
      end
      tests++;
      if (n !== 8) begin fails++; $display("FAIL to_req_cycles got %0d want 8", n); end
      tests++;
      if ({done, bus_err} !== 2'b11 || rdata !== 32'd0) begin
         fails++; $display("FAIL to_done got done=%b err=%b rdata=%h want 1 1 00000000", done, bus_err, rdata);
      end
      tick();
      drop();
      tests++;
      if ({done, bus_err, bus_req, stall} !== 4'b0000) begin
         fails++; $display("FAIL to_idle got %b want 0000", {done, bus_err, bus_req, stall});
      end
   endtask

   task automatic test_store_half();
      int stalls = 0;
      bus_ready = 1'b0;
      go(1'b1, 3'd1, 32'h102, 32'h0000ABCD);
      if (stall) stalls++;
      tick();
      tests++;
      if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata} !== {2'b11, 32'h100, 4'b1100, 32'hABCDABCD}) begin
         fails++; $display("FAIL sh_bus got req=%b we=%b addr=%h strb=%b wdata=%h want 1 1 00000100 1100 abcdabcd", bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata);
      end
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) bus_ready = 1'b1;
         if (stall) stalls++;
         tick();
      end
      tests++;
      if (stalls !== 5) begin fails++; $display("FAIL sh_stall_cycles got %0d want 5", stalls); end
      tests++;
      if ({done, stall, bus_err} !== 3'b100 || rdata !== 32'd0) begin
         fails++; $display("FAIL sh_done got done=%b stall=%b err=%b rdata=%h want 1 0 0 00000000", done, stall, bus_err, rdata);
      end
      tick();
      drop();
      bus_ready = 1'b0;
   endtask

   task automatic test_misalign();
      int reqs = 0;
      go(1'b0, 3'd2, 32'h101, 32'd0);
      tests++;
      if ({misalign, stall} !== 2'b10) begin
         fails++; $display("FAIL lw_mis got mis/stall=%b want 10", {misalign, stall});
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus_req || done) reqs++;
      end
      tests++;
      if (reqs !== 0) begin fails++; $display("FAIL lw_mis_bus got %0d active cycles want 0", reqs); end
      go(1'b0, 3'd3, 32'h100, 32'd0);
      tests++;
      if ({misalign, stall} !== 2'b10) begin
         fails++; $display("FAIL ld_f3_3 got mis/stall=%b want 10", {misalign, stall});
      end
      go(1'b0, 3'd5, 32'h101, 32'd0);
      tests++;
      if (misalign !== 1'b1) begin fails++; $display("FAIL lhu_mis got %b want 1", misalign); end
      go(1'b1, 3'd4, 32'h100, 32'd0);
      tests++;
      if (misalign !== 1'b1) begin fails++; $display("FAIL st_f3_4 got %b want 1", misalign); end
      go(1'b1, 3'd0, 32'h103, 32'd0);
      tests++;
      if (misalign !== 1'b0) begin fails++; $display("FAIL sb_ok got %b want 0", misalign); end
      drop();
      tick();
      tests++;
      if (bus_req !== 1'b0) begin fails++; $display("FAIL mis_bus_end got req=%b want 0", bus_req); end
   endtask

   task automatic test_reset_mid();
      bus_ready = 1'b0;
      go(1'b0, 3'd2, 32'h300, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      tests++;
      if ({bus_req, stall, done} !== 3'b000) begin
         fails++; $display("FAIL rst_mid got req/stall/done=%b want 000", {bus_req, stall, done});
      end
      tick();
      reset = 1'b0;
      bus_rdata = 32'h7FFF8001; bus_ready = 1'b1;
      go(1'b0, 3'd1, 32'h010, 32'd0);
      tests++;
      if ({done, stall} !== 2'b01) begin
         fails++; $display("FAIL rst_after got done/stall=%b want 01", {done, stall});
      end
      tick(); tick();
      tests++;
      if (done !== 1'b1 || rdata !== 32'hFFFF8001) begin
         fails++; $display("FAIL lh_after_rst got done=%b rdata=%h want 1 ffff8001", done, rdata);
      end
      tick();
      drop();
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      int first = -1;
      int second = -1;
      bus_ready = 1'b1; bus_rdata = 32'h11223344;
      for (int c = 0; c < 7; c++) begin
         if (c == 0) go(1'b0, 3'd2, 32'h0, 32'd0);
         else if (c == 3) go(1'b1, 3'd2, 32'h4, 32'hCAFEF00D);
         else if (c == 6) drop();
         else #1;
         if (done) begin
            ndone++;
            if (first < 0) first = c; else second = c;
         end
         if (c == 2) begin
            tests++;
            if (rdata !== 32'h11223344) begin fails++; $display("FAIL b2b_lw got %h want 11223344", rdata); end
         end
         if (c == 4) begin
            tests++;
            if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata} !== {2'b11, 32'h4, 4'b1111, 32'hCAFEF00D}) begin
               fails++; $display("FAIL b2b_sw got req=%b we=%b addr=%h strb=%b wdata=%h want 1 1 00000004 1111 cafef00d", bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata);
            end
         end
         tick();
      end
      tests++;
      if (ndone !== 2 || first !== 2 || second !== 5) begin
         fails++; $display("FAIL b2b_done got count=%0d at %0d,%0d want 2 at 2,5", ndone, first, second);
      end
   endtask

   initial begin
      mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
      bus_ready = 1'b0; bus_rdata = 32'd0; reset = 1'b1;
      test_reset();
      test_load_byte();
      test_timeout();
      test_store_half();
      test_misalign();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage for the RV32I core. It sits directly downstream of the ALU and the rs2 read port: it takes the effective address (`alu_result`) and the store data (rs2), and returns load data to the register-file write-back mux. It converts byte, halfword and word loads and stores into word-aligned bus transactions with byte strobes, using a req/ready handshake. It stalls the core until each transaction completes and flags misaligned accesses, illegal accesses and bus timeouts.

## Interface

**Parameters**

- `TIMEOUT`, 16: maximum number of BUS cycles spent waiting for `bus_ready` before the access is abandoned. 0 disables the timeout.

**Ports**

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `mem_req` in 1: the current instruction is a load or store. Held, with all core inputs stable, while `stall`=1.
- `mem_we` in 1: 1 = store, 0 = load.
- `funct3` in 3: access type. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `addr` in 32: effective byte address.
- `wdata` in 32: store data (rs2).
- `rdata` out 32: extended load data. Valid while `done`=1.
- `done` out 1: one-cycle pulse; the access is complete and the core may commit.
- `stall` out 1: freeze the PC and the register-file write.
- `misalign` out 1: combinational. The access is misaligned or uses an illegal `funct3`.
- `bus_err` out 1: one-cycle pulse with `done` when the bus wait timed out.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_wstrb` out 4: byte-lane enables. 0000 for loads.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ready` in 1: bus accepted the write or returned the read data.
- `bus_rdata` in 32: read word. Valid when `bus_ready`=1.

## Operation

**States:** IDLE, BUS, DONE.

**IDLE**
- If `mem_req` and not `misalign`: capture `mem_we`, `funct3`, `addr[1:0]`, `bus_addr`, `bus_wstrb` and `bus_wdata`, clear the wait counter, and go to BUS.
- If `mem_req` and `misalign`: stay in IDLE. No bus activity. `misalign`=1, `stall`=0. The trap is handled by the core.

**BUS**
- `bus_req`=1. All `bus_*` outputs come from registers and stay stable.
- `bus_ready`=1 at the clock edge: capture `rdata`, extended for loads, and go to DONE.
- Otherwise increment the counter. If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`: set `bus_err`, set `rdata`=0, and go to DONE.

**DONE**
- `done`=1 and `stall`=0 for exactly one cycle, then go to IDLE unconditionally.
- A new `mem_req` seen in DONE is ignored; it is taken in the following IDLE cycle. The core has advanced its PC at the DONE edge.

**`stall`** = `(IDLE & mem_req & ~misalign) | BUS`. It is forced to 0 while `reset` is high.

**`misalign`** is asserted in these cases:
- LH, LHU or SH with `addr[0]`=1.
- LW or SW with `addr[1:0]`≠0.
- Load with `funct3` ∈ {3,6,7}.
- Store with `funct3` ≥ 3.

**Store lanes**
- SB: wdata = `{4{wdata[7:0]}}`, wstrb = `4'b0001 << addr[1:0]`.
- SH: wdata = `{2{wdata[15:0]}}`, wstrb = 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
- SW: wdata = `wdata`, wstrb = 1111.

**Load extract**
- LB/LBU: select the byte `bus_rdata[8*addr[1:0] +: 8]`. Sign-extend for LB, zero-extend for LBU.
- LH/LHU: select the halfword `bus_rdata[16*addr[1] +: 16]`. Sign-extend for LH, zero-extend for LHU.
- LW: the full word.
- For stores, `rdata` is 0.

## Timing

- **Reset values:** state IDLE. `rdata`, `done`, `bus_err`, `bus_req`, `bus_we`, `bus_addr`, `bus_wstrb` and `bus_wdata` are all 0. Reset mid-BUS abandons the transaction: `bus_req` falls immediately and no `done` is produced.
- **Latency:** with `bus_ready` high in the first BUS cycle, the request is seen in cycle 0 (IDLE, `stall`=1), BUS is cycle 1, and DONE is cycle 2. Minimum total is 3 cycles with 2 stall cycles. Each extra wait cycle adds one stall cycle.
- **Bus rules:**
  - `bus_req` rises only on entry to BUS.
  - `bus_req` falls on the edge where `bus_ready`=1 is sampled or the timeout fires.
  - `bus_ready` is ignored outside BUS.
- **Timeout:** `bus_req` is high for exactly `TIMEOUT` cycles, then DONE follows with `bus_err`=1.
- **Misaligned access:** zero latency and purely combinational. The FSM is unaffected.

## Test plan

1. LB at addr 0x103, `bus_rdata`=0x80FF1234, ready in the first BUS cycle -> `bus_addr`=0x100, `bus_wstrb`=0000, `rdata`=0xFFFFFF80 with `done` at cycle 2; LBU -> 0x00000080.
2. SH at addr 0x102, `wdata`=0x0000ABCD -> `bus_we`=1, `bus_wdata`=0xABCDABCD, `bus_wstrb`=1100, `bus_addr`=0x100; with ready delayed 3 cycles, `stall` is high for 5 cycles.
3. LW at addr 0x101 -> `misalign`=1, `stall`=0, `bus_req` never rises; same result for a load with `funct3`=3 at 0x100.
4. `TIMEOUT`=8, LW at 0x200, `bus_ready` held 0 -> `bus_req` high for exactly 8 cycles, then `done`=`bus_err`=1 for one cycle, `rdata`=0, state back to IDLE.
5. `reset` pulsed on the second BUS cycle -> `bus_req`, `stall` and `done` go to 0 immediately; after release, a new LH at 0x010 with `bus_rdata`=0x7FFF8001 completes with `rdata`=0xFFFF8001.
6. Back-to-back LW 0x0 then SW 0x4, zero wait states -> two transactions 3 cycles apart, each with one `done` pulse; SW shows `bus_wstrb`=1111.
